// File: rtl/npu_mem_pkg.sv
// Shared definitions for the NPU memory responder: bus widths, responder
// state encoding and read-latency legality limits.
package npu_mem_pkg;

    localparam int MEM_ADDR_W   = 32;
    localparam int MEM_DATA_W   = 32;

    localparam int RD_LAT_MIN   = 1;
    localparam int RD_LAT_MAX   = 15;
    localparam int RD_LAT_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } resp_state_t;

    function automatic bit read_latency_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/npu_sram_1rw.sv
// Single-port scratchpad RAM, write-first, registered read data.
// Read data only changes on an enabled access, so it holds between accesses.
module npu_sram_1rw
    import npu_mem_pkg::*;
#(
    parameter int DEPTH = 16384,
    parameter int WIDTH = MEM_DATA_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/npu_mem_responder.sv
// Memory-side responder for the NPU master bus: scratchpad-backed, fixed read
// latency, zero-wait writes, range/misalignment error pulses and transfer counters.
module npu_mem_responder
    import npu_mem_pkg::*;
#(
    parameter int                    DEPTH        = 16384,
    parameter int                    READ_LATENCY = 2,
    parameter logic [MEM_ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter logic [MEM_DATA_W-1:0] ERR_DATA     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MEM_ADDR_W-1:0] mem_addr,
    input  logic [MEM_DATA_W-1:0] mem_data_out,
    input  logic                  mem_we,
    input  logic                  mem_re,
    output logic                  mem_ready,
    output logic [MEM_DATA_W-1:0] mem_data_in,
    output logic                  mem_rvalid,
    output logic                  err,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    // Illegal latencies fall back to the minimum rather than building a broken counter.
    localparam int LAT = read_latency_ok(READ_LATENCY) ? READ_LATENCY : RD_LAT_MIN;
    localparam int AW  = $clog2(DEPTH);
    localparam logic [RD_LAT_CNT_W-1:0] CNT_LOAD = RD_LAT_CNT_W'(LAT - 1);

    resp_state_t             state, state_d;
    logic [RD_LAT_CNT_W-1:0] cnt, cnt_d;
    logic                    fire;

    logic [MEM_ADDR_W-1:0]   offset, word_idx;
    logic                    out_of_range, misaligned;
    logic                    accept, rd_acc, wr_acc;
    logic                    rd_oor, err_d, pend_oor;
    logic [MEM_DATA_W-1:0]   ram_rdata, rdata_sel, data_hold;

    assign offset       = mem_addr - BASE_ADDR;
    assign word_idx     = offset >> 2;
    assign out_of_range = (mem_addr < BASE_ADDR) || (word_idx >= MEM_ADDR_W'(DEPTH));
    assign misaligned   = mem_addr[1:0] != 2'b00;

    assign mem_ready = (state == IDLE);
    assign accept    = mem_ready && (mem_re || mem_we);
    assign wr_acc    = accept && mem_we;
    assign rd_acc    = accept && mem_re && !mem_we;

    npu_sram_1rw #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_DATA_W),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (rst_n && accept && !out_of_range),
        .we    (mem_we),
        .addr  (word_idx[AW-1:0]),
        .wdata (mem_data_out),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // The RAM already supplies one cycle of latency; WAIT adds the remaining LAT-1.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rd_acc) begin
                    if (LAT == 1) begin
                        fire = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt <= RD_LAT_CNT_W'(1)) begin
                    fire    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - RD_LAT_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_oor = (state == WAIT) ? pend_oor : out_of_range;
    assign err_d  = (accept && (misaligned || (mem_we && out_of_range) || (mem_re && mem_we)))
                  || (fire && rd_oor);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_rvalid <= 1'b0;
            err        <= 1'b0;
            pend_oor   <= 1'b0;
            rd_count   <= '0;
            wr_count   <= '0;
            data_hold  <= '0;
        end else begin
            mem_rvalid <= fire;
            err        <= err_d;
            if (rd_acc)     pend_oor  <= out_of_range;
            if (fire)       rd_count  <= rd_count + 32'd1;
            if (wr_acc)     wr_count  <= wr_count + 32'd1;
            if (mem_rvalid) data_hold <= rdata_sel;
        end
    end

    // Outside the strobe cycle the bus keeps showing the last returned word.
    assign rdata_sel   = pend_oor ? ERR_DATA : ram_rdata;
    assign mem_data_in = mem_rvalid ? rdata_sel : data_hold;

endmodule

// File: tb/tb_npu_mem_responder.sv
// Scoreboard bench: three responders (latency 2, 1, 4) driven by directed vectors,
// with a negedge monitor popping expected read responses.
module tb_npu_mem_responder;

    localparam int DEPTH = 64;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam int LATS [3] = '{2, 1, 4};

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n  [3];
    logic [31:0] addr   [3];
    logic [31:0] wdata  [3];
    logic        re     [3];
    logic        we     [3];
    logic        ready  [3];
    logic [31:0] rdata  [3];
    logic        rvalid [3];
    logic        errq   [3];
    logic [31:0] rdc    [3];
    logic [31:0] wrc    [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 0;

    exp_t        exp_q [3][$];
    exp_t        mon_e;
    logic [31:0] exp_last [3];
    logic [31:0] mdl_mem  [3][DEPTH];
    int          busy     [3];
    int          mdl_rd   [3];
    int          mdl_wr   [3];
    int          exp_err  [3];
    int          err_seen [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        npu_mem_responder #(
            .DEPTH        (DEPTH),
            .READ_LATENCY (LATS[g]),
            .BASE_ADDR    (32'h0000_0000),
            .ERR_DATA     (ERR)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .mem_addr     (addr[g]),
            .mem_data_out (wdata[g]),
            .mem_we       (we[g]),
            .mem_re       (re[g]),
            .mem_ready    (ready[g]),
            .mem_data_in  (rdata[g]),
            .mem_rvalid   (rvalid[g]),
            .err          (errq[g]),
            .rd_count     (rdc[g]),
            .wr_count     (wrc[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every read strobe must match the oldest expected response, on time.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (rvalid[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checkOutput($sformatf("dut%0d unexpected_rvalid", d), 32'd1, 32'd0);
                    end else begin
                        mon_e = exp_q[d].pop_front();
                        checkOutput($sformatf("dut%0d rdata", d), rdata[d], mon_e.data);
                        checkOutput($sformatf("dut%0d rvalid_err", d), {31'b0, errq[d]}, {31'b0, mon_e.err});
                        checkOutput($sformatf("dut%0d rvalid_cycle", d), cyc, mon_e.due);
                        exp_last[d] = mon_e.data;
                    end
                end else begin
                    checkOutput($sformatf("dut%0d data_hold", d), rdata[d], exp_last[d]);
                    if (exp_q[d].size() != 0 && cyc > exp_q[d][0].due) begin
                        checkOutput($sformatf("dut%0d missing_rvalid", d), 32'd0, 32'd1);
                        void'(exp_q[d].pop_front());
                    end
                end
                if (errq[d]) err_seen[d]++;
            end
        end
    end

    task automatic applyStimulus(input int d, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] wd);
        logic acc, oor, mis;
        int   idx;
        exp_t e;
        re[d] = r; we[d] = w; addr[d] = a; wdata[d] = wd;
        checkOutput($sformatf("dut%0d ready", d), {31'b0, ready[d]}, {31'b0, busy[d] == 0});
        acc = (busy[d] == 0) && (r || w);
        oor = a >= 32'(4 * DEPTH);
        mis = a[1:0] != 2'b00;
        idx = int'(a[31:2]);
        @(posedge clk);
        #1;
        if (busy[d] > 0) busy[d]--;
        if (acc && w) begin
            mdl_wr[d]++;
            if (!oor) mdl_mem[d][idx] = wd;
            if (oor || mis || r) exp_err[d]++;
        end else if (acc) begin
            if (mis) exp_err[d]++;
            if (oor) exp_err[d]++;
            e.data = oor ? ERR : mdl_mem[d][idx];
            e.err  = oor;
            e.due  = cyc + LATS[d] - 1;
            exp_q[d].push_back(e);
            mdl_rd[d]++;
            busy[d] = LATS[d] - 1;
        end
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) applyStimulus(d, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic checkCounts(input int d);
        checkOutput($sformatf("dut%0d rd_count", d), rdc[d], 32'(mdl_rd[d]));
        checkOutput($sformatf("dut%0d wr_count", d), wrc[d], 32'(mdl_wr[d]));
        checkOutput($sformatf("dut%0d err_pulses", d), 32'(err_seen[d]), 32'(exp_err[d]));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; re[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            exp_last[d] = '0; busy[d] = 0; mdl_rd[d] = 0; mdl_wr[d] = 0;
            exp_err[d] = 0; err_seen[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        mon_en = 1'b1;

        $display("[TB] reset values");
        checkOutput("reset ready", {31'b0, ready[0]}, 32'd1);
        checkOutput("reset rvalid", {31'b0, rvalid[0]}, 32'd0);
        checkOutput("reset err", {31'b0, errq[0]}, 32'd0);
        checkOutput("reset data_in", rdata[0], 32'd0);
        checkCounts(0);

        $display("[TB] latency 2: write then read back");
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        idle(0, 3);
        checkCounts(0);

        $display("[TB] latency 2: range boundary");
        applyStimulus(0, 1'b0, 1'b1, 32'h00, 32'h0000_1111);
        applyStimulus(0, 1'b0, 1'b1, 32'hFC, 32'h0000_2222);
        applyStimulus(0, 1'b0, 1'b1, 32'h100, 32'h0000_0BAD);
        idle(0, 2);
        applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h00, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'h00, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 32'hFC, 32'h0);
        idle(0, 3);
        checkCounts(0);

        $display("[TB] latency 2: simultaneous read and write");
        applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h0000_1234);
        idle(0, 2);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0);
        idle(0, 3);
        checkCounts(0);

        $display("[TB] latency 2: misaligned read");
        applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h0000_0055);
        applyStimulus(0, 1'b1, 1'b0, 32'h22, 32'h0);
        idle(0, 3);
        checkCounts(0);

        $display("[TB] latency 1: back-to-back reads");
        for (int i = 0; i < 16; i++)
            applyStimulus(1, 1'b0, 1'b1, 32'(4 * i), 32'h0100_0000 + 32'(i * 7));
        for (int i = 0; i < 16; i++)
            applyStimulus(1, 1'b1, 1'b0, 32'(4 * i), 32'h0);
        idle(1, 3);
        checkCounts(1);

        $display("[TB] latency 4: held read and reset in WAIT");
        applyStimulus(2, 1'b0, 1'b1, 32'h40, 32'h0000_CAFE);
        repeat (5) applyStimulus(2, 1'b1, 1'b0, 32'h40, 32'h0);
        applyStimulus(2, 1'b1, 1'b0, 32'h40, 32'h0);
        rst_n[2] = 1'b0; re[2] = 1'b0;
        exp_q[2].delete();
        @(posedge clk);
        #1;
        exp_last[2] = '0;
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        busy[2] = 0; mdl_rd[2] = 0; mdl_wr[2] = 0; exp_err[2] = 0; err_seen[2] = 0;
        idle(2, 6);
        checkCounts(2);

        for (int k = 0; k < 10; k++) begin
            if (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0) @(posedge clk);
        end
        for (int d = 0; d < 3; d++)
            checkOutput($sformatf("dut%0d pending_at_end", d), 32'(exp_q[d].size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
